// File: rtl/cpu_ifetch.sv
// Instruction fetch stage: issues word-aligned icache requests under a credit
// limit, tags them with a jump epoch and queues matching responses for decode.
module cpu_ifetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hFFFF0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        ifetch_icache_request,
    input  logic        ifetch_icache_ready,
    output logic [31:0] ifetch_icache_address,
    output logic [31:0] ifetch_icache_wdata,
    input  logic [31:0] ifetch_icache_rdata,
    input  logic [31:0] ifetch_icache_raddr,
    input  logic [8:0]  ifetch_icache_rtag,
    input  logic        ifetch_icache_rvalid,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] p2_instr,
    output logic [31:0] p2_pc,
    output logic        p2_valid,
    input  logic        p2_ready
);

    logic [31:0] r_pc;
    logic [8:0]  r_epoch;
    logic [2:0]  r_inflight;
    logic [2:0]  r_count;
    logic [1:0]  r_rd_ptr;
    logic [1:0]  r_wr_ptr;
    logic [31:0] r_fifo_pc    [0:3];
    logic [31:0] r_fifo_instr [0:3];

    logic [3:0]  w_credit_sum;
    logic        w_request;
    logic        w_accept;
    logic        w_resp;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_jump_pc;

    // Outstanding requests plus queued instructions never exceed the FIFO depth,
    // so every response that is kept always finds a free slot.
    assign w_credit_sum = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_request    = reset_n && !jump && (w_credit_sum < 4'd4);
    assign w_accept     = w_request && ifetch_icache_ready;
    assign w_resp       = ifetch_icache_rvalid && (r_inflight != 3'd0);
    assign w_push       = w_resp && (ifetch_icache_rtag == r_epoch) && !jump;
    assign w_pop        = (r_count != 3'd0) && p2_ready && !jump;
    assign w_jump_pc    = jump_target & 32'hFFFF_FFFC;

    assign ifetch_icache_request = w_request;
    assign ifetch_icache_address = r_pc;
    assign ifetch_icache_wdata   = {23'd0, r_epoch};
    assign p2_valid              = (r_count != 3'd0);
    assign p2_instr              = r_fifo_instr[r_rd_ptr];
    assign p2_pc                 = r_fifo_pc[r_rd_ptr];

    // Fetch PC and epoch: redirect on jump, otherwise advance on acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc    <= RESET_VECTOR;
            r_epoch <= 9'd0;
        end else if (jump) begin
            r_pc    <= w_jump_pc;
            r_epoch <= r_epoch + 9'd1;
        end else if (w_accept) begin
            r_pc    <= r_pc + 32'd4;
        end
    end

    // In-flight counter: stale responses still return their credit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight <= 3'd0;
        end else begin
            case ({w_accept, w_resp})
                2'b10:   r_inflight <= r_inflight + 3'd1;
                2'b01:   r_inflight <= r_inflight - 3'd1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // FIFO occupancy and pointers; a jump flushes everything queued.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= 3'd0;
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
        end else if (jump) begin
            r_count  <= 3'd0;
            r_rd_ptr <= 2'd0;
            r_wr_ptr <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
        end
    end

    // FIFO storage is unreset; the head is only observed while p2_valid is high.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]    <= ifetch_icache_raddr;
            r_fifo_instr[r_wr_ptr] <= ifetch_icache_rdata;
        end
    end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Self-checking bench for cpu_ifetch: icache responder, spec model with
// expected-output scoreboard, a per-cycle vector table and corner sequences.
module tb_cpu_ifetch;

    logic        clock;
    logic        reset_n;
    logic        ifetch_icache_request;
    logic        ifetch_icache_ready;
    logic [31:0] ifetch_icache_address;
    logic [31:0] ifetch_icache_wdata;
    logic [31:0] ifetch_icache_rdata;
    logic [31:0] ifetch_icache_raddr;
    logic [8:0]  ifetch_icache_rtag;
    logic        ifetch_icache_rvalid;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] p2_instr;
    logic [31:0] p2_pc;
    logic        p2_valid;
    logic        p2_ready;

    cpu_ifetch dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .ifetch_icache_request (ifetch_icache_request),
        .ifetch_icache_ready   (ifetch_icache_ready),
        .ifetch_icache_address (ifetch_icache_address),
        .ifetch_icache_wdata   (ifetch_icache_wdata),
        .ifetch_icache_rdata   (ifetch_icache_rdata),
        .ifetch_icache_raddr   (ifetch_icache_raddr),
        .ifetch_icache_rtag    (ifetch_icache_rtag),
        .ifetch_icache_rvalid  (ifetch_icache_rvalid),
        .jump                  (jump),
        .jump_target           (jump_target),
        .p2_instr              (p2_instr),
        .p2_pc                 (p2_pc),
        .p2_valid              (p2_valid),
        .p2_ready              (p2_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [8:0]  tag;
    } req_t;

    typedef struct {
        logic        rdy;
        logic        p2r;
        logic        jmp;
        logic [31:0] jt;
        logic        resp;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;

    exp_t        sb[$];
    req_t        pend[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          tb_inflight;
    logic [8:0]  tb_epoch;
    logic [31:0] tb_pc;
    logic        tb_stray = 1'b0;
    logic        s_req;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    vec_t        tbl [0:22];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n              = 1'b0;
        ifetch_icache_ready  = 1'b0;
        ifetch_icache_rvalid = 1'b0;
        ifetch_icache_rdata  = 32'd0;
        ifetch_icache_raddr  = 32'd0;
        ifetch_icache_rtag   = 9'd0;
        jump                 = 1'b0;
        jump_target          = 32'd0;
        p2_ready             = 1'b0;
        @(posedge clock);
        #1;
        chk("reset_request", {31'd0, ifetch_icache_request}, 32'd0);
        chk("reset_p2_valid", {31'd0, p2_valid}, 32'd0);
        chk("reset_address", ifetch_icache_address, 32'hFFFF0000);
        chk("reset_wdata", ifetch_icache_wdata, 32'd0);
        sb.delete();
        pend.delete();
        tb_inflight = 0;
        tb_epoch    = 9'd0;
        tb_pc       = 32'hFFFF0000;
        reset_n     = 1'b1;
    endtask

    // One clock cycle: drive inputs, sample and check outputs, update model.
    task automatic cycle(input logic rdy, input logic p2r, input logic jmp,
                         input logic [31:0] jt, input logic resp);
        req_t r;
        exp_t e;
        logic exp_req;
        logic exp_valid;
        logic acc;
        logic resp_ok;
        ifetch_icache_ready = rdy;
        p2_ready            = p2r;
        jump                = jmp;
        jump_target         = jt;
        ifetch_icache_rvalid = 1'b0;
        if (tb_stray) begin
            ifetch_icache_rvalid = 1'b1;
            ifetch_icache_raddr  = 32'hDEAD_0000;
            ifetch_icache_rdata  = instr_of(32'hDEAD_0000);
            ifetch_icache_rtag   = tb_epoch;
        end else if (resp && pend.size() > 0) begin
            r = pend.pop_front();
            ifetch_icache_rvalid = 1'b1;
            ifetch_icache_raddr  = r.addr;
            ifetch_icache_rdata  = instr_of(r.addr);
            ifetch_icache_rtag   = r.tag;
        end
        #1;
        s_req   = ifetch_icache_request;
        s_addr  = ifetch_icache_address;
        s_wdata = ifetch_icache_wdata;
        s_valid = p2_valid;
        s_pc    = p2_pc;
        s_instr = p2_instr;

        exp_req   = !jmp && ((tb_inflight + sb.size()) < 4);
        exp_valid = (sb.size() != 0);
        chk("request", {31'd0, s_req}, {31'd0, exp_req});
        if (s_req) begin
            chk("address", s_addr, tb_pc);
            chk("wdata", s_wdata, {23'd0, tb_epoch});
        end
        chk("p2_valid", {31'd0, s_valid}, {31'd0, exp_valid});
        if (s_valid && p2r && !jmp && sb.size() > 0) begin
            e = sb.pop_front();
            chk("p2_pc", s_pc, e.pc);
            chk("p2_instr", s_instr, e.instr);
        end

        acc     = s_req && rdy;
        resp_ok = ifetch_icache_rvalid && (tb_inflight != 0);
        if (acc) begin
            r.addr = s_addr;
            r.tag  = s_wdata[8:0];
            pend.push_back(r);
        end
        if (resp_ok && (ifetch_icache_rtag == tb_epoch) && !jmp) begin
            e.pc    = ifetch_icache_raddr;
            e.instr = instr_of(ifetch_icache_raddr);
            sb.push_back(e);
        end
        tb_inflight = tb_inflight + (acc ? 1 : 0) - (resp_ok ? 1 : 0);
        if (jmp) begin
            sb.delete();
            tb_epoch = tb_epoch + 9'd1;
            tb_pc    = {jt[31:2], 2'b00};
        end else if (acc) begin
            tb_pc = tb_pc + 32'd4;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        //              rdy   p2r   jmp   jt            resp  ereq  eaddr         evalid epc
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0000, 1'b0, 32'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0004, 1'b0, 32'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0008, 1'b1, 32'hFFFF0000};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF000C, 1'b1, 32'hFFFF0004};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0010, 1'b1, 32'hFFFF0008};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0014, 1'b1, 32'hFFFF000C};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0018, 1'b1, 32'hFFFF0010};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF001C, 1'b1, 32'hFFFF0010};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b1, 32'hFFFF0010};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b1, 32'hFFFF0010};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b1, 32'hFFFF0010};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0020, 1'b1, 32'hFFFF0014};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b1, 32'hFFFF0014};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b1, 32'hFFFF0014};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b0, 32'd0,        1'b1, 32'hFFFF0014};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0024, 1'b1, 32'hFFFF0018};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0024, 1'b1, 32'hFFFF001C};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFF0024, 1'b1, 32'hFFFF0020};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd0,        1'b0, 32'd0};
        tbl[19] = '{1'b1, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 32'd0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'h00000000, 1'b0, 32'd0};
        tbl[21] = '{1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'h00000000, 1'b1, 32'hFFFFFFFC};
        tbl[22] = '{1'b0, 1'b1, 1'b0, 32'd0,        1'b1, 1'b1, 32'h00000000, 1'b0, 32'd0};

        // In-order streaming, FIFO fill under backpressure, wrap at top of memory.
        do_reset();
        for (int i = 0; i < 23; i++) begin
            cycle(tbl[i].rdy, tbl[i].p2r, tbl[i].jmp, tbl[i].jt, tbl[i].resp);
            chk($sformatf("tbl%0d_req", i), {31'd0, s_req}, {31'd0, tbl[i].ereq});
            if (tbl[i].ereq) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].eaddr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, s_valid}, {31'd0, tbl[i].evalid});
            if (tbl[i].evalid) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].epc);
        end

        // Jump with three responses outstanding: old ones discarded but hold credits.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h00001003, 1'b0);
        chk("jmp_no_req", {31'd0, s_req}, 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("jmp_addr", s_addr, 32'h00001000);
        chk("jmp_wdata", s_wdata, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("jmp_credit_full", {31'd0, s_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);
            chk("jmp_stale_drop", {31'd0, s_valid}, 32'd0);
        end
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("jmp_new_valid", {31'd0, s_valid}, 32'd1);
        chk("jmp_new_pc", s_pc, 32'h00001000);
        chk("jmp_credit_back", {31'd0, s_req}, 32'd1);

        // Jump coinciding with a matching response and a pop.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 32'h00002000, 1'b1);
        chk("jpop_valid_before", {31'd0, s_valid}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("jpop_valid_after", {31'd0, s_valid}, 32'd0);
        chk("jpop_addr", s_addr, 32'h00002000);

        // Stray response with nothing in flight.
        do_reset();
        tb_stray = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        tb_stray = 1'b0;
        cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        chk("stray_valid", {31'd0, s_valid}, 32'd0);
        chk("stray_req", {31'd0, s_req}, 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("stray_credit_limit", {31'd0, s_req}, 32'd0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 32'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
